spi_slv: RTL and testbench

SPI_SLV -- requirements
Module: spi_slv

---
 rtl/spi_pkg.sv | 14 +
 rtl/sync_ff.sv | 27 ++
 rtl/spi_slv.sv | 226 ++++++++++++++++++++++
 tb/tb_spi_slv.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave block.
package spi_pkg;

    // Transaction sequencing for the slave.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } spi_slv_state_t;

    // Bit order on the wire: the response word goes out MSB first.
    localparam bit SPI_MSB_FIRST = 1'b1;

endpackage : spi_pkg

// File: rtl/sync_ff.sv
// Multi-stage flip-flop synchronizer for a single asynchronous input bit.
module sync_ff #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_chain;

    // Shift the asynchronous input through the chain; the last stage is the clean copy.
    always_ff @(posedge clk) begin
        // NOTE: reset value is chosen so the chain looks like the idle line level,
        // which keeps the edge detectors downstream quiet coming out of reset.
        if (!reset_n) begin
            r_chain <= {STAGES{RESET_VAL}};
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_chain[STAGES-1];

endmodule : sync_ff

// File: rtl/spi_slv.sv
// SPI mode-0 slave, oversampled by the system clock. SCLK, SS_N and MOSI are
// synchronized into clk, edges are found on the synchronized copies, and a
// small IDLE/ACTIVE/DONE machine frames each transaction.
module spi_slv
    import spi_pkg::*;
#(
    parameter int SPI_MAXLEN  = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          SCLK,
    input  logic                          SS_N,
    input  logic                          MOSI,
    output logic                          MISO,
    input  logic [SPI_MAXLEN-1:0]         tx_data,
    output logic [SPI_MAXLEN-1:0]         rx_data,
    output logic [$clog2(SPI_MAXLEN):0]   rx_nbits,
    output logic                          rx_valid,
    output logic                          rx_ovf,
    output logic                          busy
);

    localparam int CNT_W  = $clog2(SPI_MAXLEN) + 1;
    localparam int WARM_W = $clog2(SYNC_STAGES + 2);

    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(SPI_MAXLEN);
    // Edges are trusted only once both the synchronizer output and its delayed
    // copy hold values sampled after reset was released.
    localparam logic [WARM_W-1:0] WARM_DONE = WARM_W'(SYNC_STAGES + 1);

    // ------------------------------------------------------------------
    // Synchronizers
    // ------------------------------------------------------------------
    logic w_sclk_s;
    logic w_ss_n_s;
    logic w_mosi_s;

    sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk     (clk),
        .reset_n (reset_n),
        .i_d     (SCLK),
        .o_q     (w_sclk_s)
    );

    sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss_n (
        .clk     (clk),
        .reset_n (reset_n),
        .i_d     (SS_N),
        .o_q     (w_ss_n_s)
    );

    sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk     (clk),
        .reset_n (reset_n),
        .i_d     (MOSI),
        .o_q     (w_mosi_s)
    );

    // ------------------------------------------------------------------
    // Edge detection
    // ------------------------------------------------------------------
    logic                r_sclk_d;
    logic                r_ss_n_d;
    logic [WARM_W-1:0]   r_warm;

    logic w_sclk_rise;
    logic w_sclk_fall;
    logic w_ss_n_fall;
    logic w_ss_n_rise;
    logic w_start;

    // Delayed copies for edge detection, plus a post-reset settle counter so a
    // select line already low at reset release is not mistaken for a new frame.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is always updated with non-blocking assignments
        // so every flop samples the pre-edge values of its neighbours.
        if (!reset_n) begin
            r_sclk_d <= 1'b0;
            r_ss_n_d <= 1'b1;
            r_warm   <= '0;
        end else begin
            r_sclk_d <= w_sclk_s;
            r_ss_n_d <= w_ss_n_s;
            if (r_warm != WARM_DONE) begin
                r_warm <= r_warm + WARM_W'(1);
            end
        end
    end

    assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
    assign w_sclk_fall = ~w_sclk_s & r_sclk_d;
    assign w_ss_n_fall = ~w_ss_n_s & r_ss_n_d;
    assign w_ss_n_rise = w_ss_n_s & ~r_ss_n_d;
    assign w_start     = w_ss_n_fall & (r_warm == WARM_DONE);

    // ------------------------------------------------------------------
    // Transaction state machine
    // ------------------------------------------------------------------
    spi_slv_state_t r_state;
    spi_slv_state_t w_next_state;

    logic w_busy;
    logic w_miso;
    logic w_done;
    logic w_tx_bit;

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode: select falling opens a frame, select rising closes it.
    always_comb begin
        // NOTE: default first so every path assigns the signal and no latch is inferred.
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_start)     w_next_state = ACTIVE;
            ACTIVE:  if (w_ss_n_rise) w_next_state = DONE;
            DONE:                     w_next_state = IDLE;
            default:                  w_next_state = IDLE;
        endcase
    end

    // State-dependent outputs: MISO only drives data while a frame is open.
    always_comb begin
        w_busy = 1'b0;
        w_miso = 1'b0;
        w_done = 1'b0;
        case (r_state)
            ACTIVE: begin
                w_busy = 1'b1;
                w_miso = w_tx_bit;
            end
            DONE: begin
                w_done = 1'b1;
            end
            default: begin
                w_busy = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Shift registers and bit counter
    // ------------------------------------------------------------------
    logic [SPI_MAXLEN-1:0] r_tx_shift;
    logic [SPI_MAXLEN-1:0] r_rx_shift;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_ovf;

    assign w_tx_bit = SPI_MSB_FIRST ? r_tx_shift[SPI_MAXLEN-1] : r_tx_shift[0];

    // Load on frame start; sample MOSI on SCLK rise, advance MISO on SCLK fall.
    // A clock edge coinciding with select rising is still handled here because
    // the state is ACTIVE on that cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_tx_shift <= '0;
            r_rx_shift <= '0;
            r_cnt      <= '0;
            r_ovf      <= 1'b0;
        end else if (r_state == IDLE) begin
            if (w_start) begin
                r_tx_shift <= tx_data;
                r_rx_shift <= '0;
                r_cnt      <= '0;
                r_ovf      <= 1'b0;
            end
        end else if (r_state == ACTIVE) begin
            if (w_sclk_rise) begin
                r_rx_shift <= {r_rx_shift[SPI_MAXLEN-2:0], w_mosi_s};
                if (r_cnt == CNT_MAX) begin
                    r_ovf <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
            if (w_sclk_fall) begin
                if (SPI_MSB_FIRST) begin
                    r_tx_shift <= {r_tx_shift[SPI_MAXLEN-2:0], 1'b0};
                end else begin
                    r_tx_shift <= {1'b0, r_tx_shift[SPI_MAXLEN-1:1]};
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Result registers
    // ------------------------------------------------------------------
    logic [SPI_MAXLEN-1:0] r_rx_data;
    logic [CNT_W-1:0]      r_rx_nbits;
    logic                  r_rx_ovf;
    logic                  r_rx_valid;

    // Publish the finished frame; the results hold until the next frame ends,
    // and the valid pulse lines up with the freshly updated results.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rx_data  <= '0;
            r_rx_nbits <= '0;
            r_rx_ovf   <= 1'b0;
            r_rx_valid <= 1'b0;
        end else begin
            r_rx_valid <= w_done;
            if (w_done) begin
                r_rx_data  <= r_rx_shift;
                r_rx_nbits <= r_cnt;
                r_rx_ovf   <= r_ovf;
            end
        end
    end

    assign MISO     = w_miso;
    assign busy     = w_busy;
    assign rx_data  = r_rx_data;
    assign rx_nbits = r_rx_nbits;
    assign rx_ovf   = r_rx_ovf;
    assign rx_valid = r_rx_valid;

endmodule : spi_slv

// File: tb/tb_spi_slv.sv
// Self-checking bench for spi_slv: a behavioural SPI master drives frames and a
// queue-based reference model predicts what the slave reports and returns.
module tb_spi_slv;

    localparam int HALF = 8;   // clk cycles per SCLK phase (clk/SCLK ratio 16)

    logic        clk;
    logic        reset_n;
    logic        sclk;
    logic        ss_n;
    logic        mosi;
    logic        miso;
    logic [31:0] tx_data;
    logic [31:0] rx_data;
    logic [5:0]  rx_nbits;
    logic        rx_valid;
    logic        rx_ovf;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] data;
        logic [5:0]  nbits;
        logic        ovf;
    } res_t;

    res_t res_q[$];
    int   long_pulses = 0;
    logic prev_valid  = 1'b0;
    logic busy_mid;

    spi_slv #(.SPI_MAXLEN(32), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .SCLK     (sclk),
        .SS_N     (ss_n),
        .MOSI     (mosi),
        .MISO     (miso),
        .tx_data  (tx_data),
        .rx_data  (rx_data),
        .rx_nbits (rx_nbits),
        .rx_valid (rx_valid),
        .rx_ovf   (rx_ovf),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Collect every completion report, sampled away from the active edge.
    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            res_q.push_back('{rx_data, rx_nbits, rx_ovf});
            if (prev_valid === 1'b1) long_pulses++;
        end
        prev_valid = rx_valid;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers (stimulus and model only) ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Master: MSB first, mode 0. Returns the bits it captured on MISO.
    task automatic spi_xfer(input logic [63:0] w, input int n, input logic [31:0] tx,
                            input bit keep_ss, output logic [63:0] cap);
        cap = '0;
        tx_data = tx;
        ss_n = 1'b0;
        for (int i = 0; i < n; i++) begin
            mosi = w[n-1-i];
            tick(HALF);
            cap = {cap[62:0], miso};
            if (i == 0) busy_mid = busy;
            sclk = 1'b1;
            tick(HALF);
            sclk = 1'b0;
        end
        if (!keep_ss) begin
            tick(HALF);
            ss_n = 1'b1;
        end
    endtask

    task automatic get_result(output res_t r, output bit got);
        got = 1'b0;
        r.data = '0; r.nbits = '0; r.ovf = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            if (res_q.size() > 0) begin
                r = res_q.pop_front();
                got = 1'b1;
            end else begin
                tick(1);
            end
        end
    endtask

    // Slave keeps only the most recent 32 bits; the count saturates.
    function automatic void model_rx(input logic [63:0] w, input int n,
                                     output logic [31:0] d, output logic [5:0] nb,
                                     output logic ovf);
        bit q[$];
        d = '0;
        for (int i = 0; i < n; i++) begin
            q.push_back(w[n-1-i]);
            if (q.size() > 32) void'(q.pop_front());
        end
        foreach (q[i]) d = {d[30:0], q[i]};
        nb  = (n > 32) ? 6'd32 : 6'(n);
        ovf = (n > 32);
    endfunction

    // Master sees the response word MSB first, then zeros past 32 bits.
    function automatic logic [63:0] model_miso(input logic [31:0] tx, input int n);
        logic [63:0] m = '0;
        for (int i = 0; i < n; i++) m = {m[62:0], (i < 32) ? tx[31-i] : 1'b0};
        return m;
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset_n = 1'b0; ss_n = 1'b1; sclk = 1'b0; mosi = 1'b0; tx_data = 32'hFFFF_FFFF;
        tick(6);
        n_checks++;
        if ({miso, rx_valid, rx_ovf, busy} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got miso/valid/ovf/busy=%b expected 0000", {miso, rx_valid, rx_ovf, busy});
        end
        n_checks++;
        if (rx_nbits !== 6'd0) begin n_fail++; $display("FAIL reset_nbits: got %0d expected 0", rx_nbits); end
        n_checks++;
        if (rx_data !== 32'd0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", rx_data); end
        reset_n = 1'b1;
        tick(10);
    endtask

    task automatic test_idle_sclk();
        for (int i = 0; i < 3; i++) begin
            sclk = 1'b1; tick(HALF); sclk = 1'b0; tick(HALF);
        end
        tick(10);
        n_checks++;
        if (res_q.size() !== 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_sclk: got %0d reports busy=%b expected 0 reports busy=0", res_q.size(), busy);
        end
        res_q.delete();
    endtask

    task automatic test_basic();
        logic [63:0] cap; res_t r; bit got;
        spi_xfer(64'h3C, 8, 32'hA500_0000, 1'b0, cap);
        get_result(r, got);
        n_checks++;
        if (!got) begin n_fail++; $display("FAIL basic_valid: got no rx_valid expected one pulse"); end
        n_checks++;
        if (r.data !== 32'h0000_003C) begin n_fail++; $display("FAIL basic_data: got %h expected 0000003c", r.data); end
        n_checks++;
        if (r.nbits !== 6'd8 || r.ovf !== 1'b0) begin
            n_fail++; $display("FAIL basic_nbits_ovf: got %0d/%b expected 8/0", r.nbits, r.ovf);
        end
        n_checks++;
        if (cap[7:0] !== 8'hA5) begin n_fail++; $display("FAIL basic_miso: got %b expected 10100101", cap[7:0]); end
        n_checks++;
        if (busy_mid !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b expected 1 mid-frame", busy_mid); end
        tick(20);
        n_checks++;
        if (res_q.size() !== 0 || long_pulses !== 0) begin
            n_fail++; $display("FAIL basic_one_pulse: got %0d extra, %0d long expected 0/0", res_q.size(), long_pulses);
        end
        n_checks++;
        if (rx_data !== 32'h0000_003C || busy !== 1'b0 || miso !== 1'b0) begin
            n_fail++; $display("FAIL basic_hold: got data=%h busy=%b miso=%b expected 0000003c 0 0", rx_data, busy, miso);
        end
        res_q.delete();
    endtask

    task automatic test_full32();
        logic [63:0] cap; res_t r; bit got;
        spi_xfer(64'hDEAD_BEEF, 32, 32'h1234_5678, 1'b0, cap);
        get_result(r, got);
        n_checks++;
        if (!got || r.data !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL full32_data: got %h (valid=%b) expected deadbeef", r.data, got);
        end
        n_checks++;
        if (r.nbits !== 6'd32 || r.ovf !== 1'b0) begin
            n_fail++; $display("FAIL full32_nbits_ovf: got %0d/%b expected 32/0", r.nbits, r.ovf);
        end
        n_checks++;
        if (cap[31:0] !== 32'h1234_5678) begin n_fail++; $display("FAIL full32_miso: got %h expected 12345678", cap[31:0]); end
        tick(20);
        res_q.delete();
    endtask

    task automatic test_overflow();
        logic [63:0] cap; res_t r; bit got;
        spi_xfer(64'h3_0000_0001, 34, 32'hFFFF_FFFF, 1'b0, cap);
        get_result(r, got);
        n_checks++;
        if (!got || r.data !== 32'h0000_0001) begin
            n_fail++; $display("FAIL ovf_data: got %h (valid=%b) expected 00000001", r.data, got);
        end
        n_checks++;
        if (r.nbits !== 6'd32 || r.ovf !== 1'b1) begin
            n_fail++; $display("FAIL ovf_flag: got %0d/%b expected 32/1", r.nbits, r.ovf);
        end
        n_checks++;
        if (cap[33:0] !== 34'h3_FFFF_FFFC) begin n_fail++; $display("FAIL ovf_miso: got %h expected 3fffffffc", cap[33:0]); end
        tick(20);
        res_q.delete();
    endtask

    task automatic test_zero_bits();
        res_t r; bit got;
        ss_n = 1'b0; tick(10); ss_n = 1'b1;
        get_result(r, got);
        n_checks++;
        if (!got || r.nbits !== 6'd0 || r.data !== 32'd0 || r.ovf !== 1'b0) begin
            n_fail++; $display("FAIL zero_bits: got valid=%b nbits=%0d data=%h ovf=%b expected 1/0/0/0", got, r.nbits, r.data, r.ovf);
        end
        tick(20);
        res_q.delete();
    endtask

    task automatic test_reset_mid();
        logic [63:0] cap; res_t r; bit got;
        spi_xfer(64'hF0, 4, 32'hFFFF_FFFF, 1'b1, cap);
        reset_n = 1'b0; tick(5); reset_n = 1'b1;
        tick(20);
        n_checks++;
        if (res_q.size() !== 0 || busy !== 1'b0 || miso !== 1'b0 || rx_nbits !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_mid_idle: got reports=%0d busy=%b miso=%b nbits=%0d expected 0/0/0/0", res_q.size(), busy, miso, rx_nbits);
        end
        ss_n = 1'b1; tick(10);
        n_checks++;
        if (res_q.size() !== 0) begin n_fail++; $display("FAIL reset_mid_discard: got %0d reports expected 0", res_q.size()); end
        res_q.delete();
        spi_xfer(64'h81, 8, 32'h6600_0000, 1'b0, cap);
        get_result(r, got);
        n_checks++;
        if (!got || r.data !== 32'h81 || r.nbits !== 6'd8 || r.ovf !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_next: got valid=%b data=%h nbits=%0d ovf=%b expected 1/00000081/8/0", got, r.data, r.nbits, r.ovf);
        end
        n_checks++;
        if (cap[7:0] !== 8'h66) begin n_fail++; $display("FAIL reset_mid_miso: got %h expected 66", cap[7:0]); end
        tick(20);
        res_q.delete();
    endtask

    task automatic test_back_to_back();
        logic [63:0] cap_a, cap_b, wa, wb; logic [31:0] ta, tb_w;
        logic [31:0] ed; logic [5:0] en; logic eo;
        res_t r; bit got;
        wa = {32'd0, $urandom()}; wb = {32'd0, $urandom()};
        ta = $urandom(); tb_w = $urandom();
        spi_xfer(wa, 16, ta, 1'b0, cap_a);
        tick(4);
        spi_xfer(wb, 12, tb_w, 1'b0, cap_b);
        for (int k = 0; k < 2; k++) begin
            get_result(r, got);
            if (k == 0) model_rx(wa, 16, ed, en, eo); else model_rx(wb, 12, ed, en, eo);
            n_checks++;
            if (!got || r.data !== ed || r.nbits !== en || r.ovf !== eo) begin
                n_fail++;
                $display("FAIL b2b_frame%0d: got valid=%b data=%h nbits=%0d ovf=%b expected %h/%0d/%b", k, got, r.data, r.nbits, r.ovf, ed, en, eo);
            end
        end
        n_checks++;
        if (cap_a[15:0] !== model_miso(ta, 16)
            || cap_b[11:0] !== model_miso(tb_w, 12)) begin
            n_fail++; $display("FAIL b2b_miso: got %h/%h expected %h/%h", cap_a[15:0], cap_b[11:0], ta[31:16], tb_w[31:20]);
        end
        tick(20);
        res_q.delete();
    endtask

    task automatic test_random();
        logic [63:0] cap, w, em; logic [31:0] tx, ed; logic [5:0] en; logic eo;
        int n; res_t r; bit got;
        for (int it = 0; it < 6; it++) begin
            n  = $urandom_range(0, 40);
            w  = {$urandom(), $urandom()};
            tx = $urandom();
            spi_xfer(w, n, tx, 1'b0, cap);
            get_result(r, got);
            model_rx(w, n, ed, en, eo);
            em = model_miso(tx, n);
            n_checks++;
            if (!got || r.data !== ed || r.nbits !== en || r.ovf !== eo) begin
                n_fail++;
                $display("FAIL rand%0d_rx n=%0d: got valid=%b data=%h nbits=%0d ovf=%b expected %h/%0d/%b", it, n, got, r.data, r.nbits, r.ovf, ed, en, eo);
            end
            n_checks++;
            if (cap !== em) begin n_fail++; $display("FAIL rand%0d_miso n=%0d: got %h expected %h", it, n, cap, em); end
            tick(10);
            res_q.delete();
        end
    endtask

    initial begin
        busy_mid = 1'b0;
        test_reset();
        test_idle_sclk();
        test_basic();
        test_full32();
        test_overflow();
        test_zero_bits();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_spi_slv
